// File: rtl/fx2_stream_tx.sv
// fx2_stream_tx: streams 32-bit FIFO words to an FX2 slave FIFO as 16-bit halves with idle-flush packet commit
module fx2_stream_tx #(
  parameter int PKT_WORDS     = 256,
  parameter int FLUSH_TIMEOUT = 1024
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        EN,
  input  logic        FIFO_EMPTY,
  input  logic [31:0] FIFO_DATA,
  output logic        FIFO_READ,
  input  logic [2:0]  USB_STREAM_FLAGS_N,
  input  logic        USB_STREAM_FX2RDY,
  output logic [15:0] USB_STREAM_DATA_O,
  output logic        USB_STREAM_SLWR_N,
  output logic        USB_STREAM_PKTEND_N,
  output logic [1:0]  USB_STREAM_FIFOADDR,
  output logic        USB_STREAM_SLOE_N,
  output logic        USB_STREAM_SLRD_N,
  output logic [31:0] WORD_CNT
);
  localparam int PW = $clog2(PKT_WORDS + 1);
  localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, PKTEND} state_t;
  state_t        state_q, state_d;
  logic [31:0]   hold_q, hold_d;
  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [31:0]   word_cnt_q, word_cnt_d;
  logic          run_q;
  logic          rdy, wr, wr_hi, last, flush, start, chain, commit, tmo;
  logic          unused_flags;
  assign unused_flags        = ^{USB_STREAM_FLAGS_N[2], USB_STREAM_FLAGS_N[0]};
  assign USB_STREAM_FIFOADDR = 2'b10;
  assign USB_STREAM_SLOE_N   = 1'b1;
  assign USB_STREAM_SLRD_N   = 1'b1;
  assign WORD_CNT            = word_cnt_q;
  // Handshake decode, next-state and datapath updates; run_q keeps the first cycle after reset release quiet
  always_comb begin
    rdy    = USB_STREAM_FLAGS_N[1];
    wr     = (state_q == WR_LO || state_q == WR_HI) && rdy;
    wr_hi  = wr && state_q == WR_HI;
    last   = pkt_cnt_q == PW'(PKT_WORDS - 1);
    tmo    = timer_q == TW'(FLUSH_TIMEOUT - 1);
    flush  = state_q == IDLE && pkt_cnt_q != '0 && tmo;
    start  = run_q && state_q == IDLE && !flush && EN && !FIFO_EMPTY && USB_STREAM_FX2RDY && rdy;
    chain  = wr_hi && !last && EN && !FIFO_EMPTY;
    commit = state_q == PKTEND && rdy;
    FIFO_READ = start || chain;
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = flush ? PKTEND : start ? WR_LO : IDLE;
      WR_LO:   state_d = wr ? WR_HI : WR_LO;
      WR_HI:   state_d = wr ? (chain ? WR_LO : IDLE) : WR_HI;
      PKTEND:  state_d = commit ? IDLE : PKTEND;
      default: state_d = IDLE;
    endcase
    hold_d     = FIFO_READ ? FIFO_DATA : hold_q;
    pkt_cnt_d  = (commit || (wr_hi && last)) ? '0 : wr ? pkt_cnt_q + PW'(1) : pkt_cnt_q;
    timer_d    = (wr || commit) ? '0 :
                 (state_q == IDLE && pkt_cnt_q != '0 && !tmo) ? timer_q + TW'(1) : timer_q;
    word_cnt_d = wr_hi ? word_cnt_q + 32'd1 : word_cnt_q;
    USB_STREAM_SLWR_N   = !wr;
    USB_STREAM_PKTEND_N = !commit;
    USB_STREAM_DATA_O   = state_q == WR_HI ? hold_q[31:16] : hold_q[15:0];
  end
  // State and datapath registers, cleared asynchronously
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      pkt_cnt_q  <= '0;
      timer_q    <= '0;
      word_cnt_q <= '0;
      run_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      pkt_cnt_q  <= pkt_cnt_d;
      timer_q    <= timer_d;
      word_cnt_q <= word_cnt_d;
      run_q      <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fx2_stream_tx.sv
// tb_fx2_stream_tx: directed checks of FX2 streaming, back-pressure, gating, flush, reset and count wrap
module tb_fx2_stream_tx;
  localparam int FT = 16;
  logic        CLK, RST_N, EN, FIFO_EMPTY, FIFO_READ;
  logic [31:0] FIFO_DATA, WORD_CNT;
  logic [2:0]  FLAGS_N;
  logic        FX2RDY, SLWR_N, PKTEND_N, SLOE_N, SLRD_N;
  logic [15:0] DATA_O;
  logic [1:0]  FIFOADDR;
  logic [31:0] mem [0:63];
  int          wp = 0, rp = 0, cyc = 0;
  logic [15:0] wlog [0:255];
  int          wcyc [0:255];
  int          wn = 0, rd_n = 0, pe_n = 0, pe_cyc = 0, bad_rd = 0;
  int          n_cmp = 0, n_bad = 0;
  int          b, r0, p0;
  logic [31:0] pat [0:3];

  fx2_stream_tx #(.PKT_WORDS(8), .FLUSH_TIMEOUT(FT)) dut (
    .CLK(CLK), .RST_N(RST_N), .EN(EN), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
    .FIFO_READ(FIFO_READ), .USB_STREAM_FLAGS_N(FLAGS_N), .USB_STREAM_FX2RDY(FX2RDY),
    .USB_STREAM_DATA_O(DATA_O), .USB_STREAM_SLWR_N(SLWR_N), .USB_STREAM_PKTEND_N(PKTEND_N),
    .USB_STREAM_FIFOADDR(FIFOADDR), .USB_STREAM_SLOE_N(SLOE_N), .USB_STREAM_SLRD_N(SLRD_N),
    .WORD_CNT(WORD_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign FIFO_EMPTY = (rp == wp);
  assign FIFO_DATA  = mem[rp[5:0]];

  // upstream FWFT FIFO pops on the edge where FIFO_READ is high
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (FIFO_READ) rp <= rp + 1;
  end

  // bus monitor sampled mid-cycle
  always @(negedge CLK) begin
    if (!SLWR_N && wn < 256) begin
      wlog[wn] = DATA_O;
      wcyc[wn] = cyc;
      wn = wn + 1;
    end
    if (!PKTEND_N) begin
      pe_n = pe_n + 1;
      pe_cyc = cyc;
    end
    if (FIFO_READ) rd_n = rd_n + 1;
    if (FIFO_READ && FIFO_EMPTY) bad_rd = bad_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    mem[wp[5:0]] = d;
    wp = wp + 1;
  endtask

  initial begin
    RST_N = 1'b0; EN = 1'b1; FX2RDY = 1'b1; FLAGS_N = 3'b111;
    push(32'hDEADBEEF);
    tick(2);
    chk("rst_read", {31'b0, FIFO_READ}, 32'd0);
    chk("rst_slwr", {31'b0, SLWR_N}, 32'd1);
    chk("rst_pktend", {31'b0, PKTEND_N}, 32'd1);
    chk("rst_data", {16'b0, DATA_O}, 32'd0);
    chk("rst_wcnt", WORD_CNT, 32'd0);
    chk("const_pins", {28'b0, FIFOADDR, SLOE_N, SLRD_N}, 32'hB);
    RST_N = 1'b1;
    #1;
    chk("release_quiet", {30'b0, FIFO_READ, SLWR_N}, 32'd1);
    tick(1);
    chk("first_read", {31'b0, FIFO_READ}, 32'd1);
    tick(40);
    chk("sw_nwr", wn, 2);
    chk("sw_lo", {16'b0, wlog[0]}, 32'h0000BEEF);
    chk("sw_hi", {16'b0, wlog[1]}, 32'h0000DEAD);
    chk("sw_consec", wcyc[1] - wcyc[0], 1);
    chk("sw_reads", rd_n, 1);
    chk("sw_wcnt", WORD_CNT, 32'd1);
    chk("sw_pktend_n", pe_n, 1);
    chk("sw_pktend_dly", pe_cyc - wcyc[1], FT + 1);

    b = wn; r0 = rd_n; p0 = pe_n;
    pat[0] = 32'h11112222; pat[1] = 32'h33334444; pat[2] = 32'h55556666; pat[3] = 32'h77778888;
    for (int i = 0; i < 4; i++) push(pat[i]);
    tick(15);
    chk("pkt_nwr", wn - b, 8);
    chk("pkt_consec", wcyc[b+7] - wcyc[b], 7);
    for (int i = 0; i < 4; i++) begin
      chk("pkt_lo", {16'b0, wlog[b+2*i]}, {16'b0, pat[i][15:0]});
      chk("pkt_hi", {16'b0, wlog[b+2*i+1]}, {16'b0, pat[i][31:16]});
    end
    chk("pkt_reads", rd_n - r0, 4);
    chk("pkt_wcnt", WORD_CNT, 32'd5);
    tick(25);
    chk("pkt_no_pktend", pe_n - p0, 0);
    chk("pkt_cnt_zero", 32'(dut.pkt_cnt_q), 32'd0);

    b = wn; p0 = pe_n;
    push(32'h12345678);
    tick(2);
    FLAGS_N = 3'b101;
    #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {15'b0, SLWR_N, DATA_O}, 32'h00011234);
      tick(1);
    end
    FLAGS_N = 3'b111;
    tick(3);
    chk("bp_nwr", wn - b, 2);
    chk("bp_lo", {16'b0, wlog[b]}, 32'h00005678);
    chk("bp_hi", {16'b0, wlog[b+1]}, 32'h00001234);
    chk("bp_gap", wcyc[b+1] - wcyc[b], 6);
    chk("bp_wcnt", WORD_CNT, 32'd6);
    tick(30);
    chk("bp_flush", pe_n - p0, 1);

    b = wn; r0 = rd_n;
    EN = 1'b0;
    push(32'hCAFEF00D);
    tick(5);
    chk("gate_en", rd_n - r0, 0);
    EN = 1'b1; FX2RDY = 1'b0;
    tick(5);
    chk("gate_rdy", rd_n - r0, 0);
    chk("gate_nowr", wn - b, 0);
    FX2RDY = 1'b1;
    tick(1);
    FX2RDY = 1'b0; EN = 1'b0;
    push(32'h0F0F1E1E);
    tick(4);
    chk("gate_nwr", wn - b, 2);
    chk("gate_lo", {16'b0, wlog[b]}, 32'h0000F00D);
    chk("gate_hi", {16'b0, wlog[b+1]}, 32'h0000CAFE);
    chk("gate_reads", rd_n - r0, 1);
    chk("gate_wcnt", WORD_CNT, 32'd7);
    tick(30);
    EN = 1'b1; FX2RDY = 1'b1;
    tick(5);
    chk("gate_resume_lo", {16'b0, wlog[b+2]}, 32'h00001E1E);
    chk("gate_resume_hi", {16'b0, wlog[b+3]}, 32'h00000F0F);
    chk("gate_resume_wcnt", WORD_CNT, 32'd8);
    tick(30);

    push(32'hA1A1B2B2);
    push(32'hC3C3D4D4);
    tick(2);
    chk("rst_pre", {15'b0, SLWR_N, DATA_O}, 32'h0000A1A1);
    RST_N = 1'b0;
    #1;
    chk("rst_mid_out", {13'b0, SLWR_N, PKTEND_N, FIFO_READ, DATA_O}, 32'h00060000);
    chk("rst_mid_wcnt", WORD_CNT, 32'd0);
    b = wn;
    tick(2);
    RST_N = 1'b1;
    tick(8);
    chk("rst_nwr", wn - b, 2);
    chk("rst_next_lo", {16'b0, wlog[b]}, 32'h0000D4D4);
    chk("rst_next_hi", {16'b0, wlog[b+1]}, 32'h0000C3C3);
    chk("rst_wcnt", WORD_CNT, 32'd1);
    tick(30);

    force dut.word_cnt_q = 32'hFFFFFFFF;
    tick(1);
    release dut.word_cnt_q;
    tick(1);
    chk("wrap_pre", WORD_CNT, 32'hFFFFFFFF);
    push(32'h0BADF00D);
    tick(6);
    chk("wrap", WORD_CNT, 32'd0);
    tick(30);
    chk("rd_empty", bad_rd, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fx2_stream_tx.md
FX2_STREAM_TX -- requirements
Module: fx2_stream_tx

Interface
REQ-001 SHALL have parameter PKT_WORDS, default 256, giving the 16-bit words per USB packet; it must be even and at least 2.
REQ-002 SHALL have parameter FLUSH_TIMEOUT, default 1024, giving the STREAM_CLK idle cycles before a partial packet is committed.
REQ-003 SHALL have port CLK, input, 1 bit: STREAM_CLK domain clock; the block uses one clock only.
REQ-004 SHALL have port RST_N, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port EN, input, 1 bit: streaming enable.
REQ-006 SHALL have port FIFO_EMPTY, input, 1 bit: upstream trigger-data FIFO empty (first-word-fall-through).
REQ-007 SHALL have port FIFO_DATA, input, 32 bits: FIFO head word, valid while FIFO_EMPTY=0.
REQ-008 SHALL have port FIFO_READ, output, 1 bit: pop strobe, one cycle per word.
REQ-009 SHALL have port USB_STREAM_FLAGS_N, input, 3 bits: FX2 flags; bit 1 = 1 means the endpoint is not full.
REQ-010 SHALL have port USB_STREAM_FX2RDY, input, 1 bit: FX2 ready to accept stream data.
REQ-011 SHALL have port USB_STREAM_DATA_O, output, 16 bits: FX2 data bus.
REQ-012 SHALL have port USB_STREAM_SLWR_N, output, 1 bit: FX2 write strobe, active-low.
REQ-013 SHALL have port USB_STREAM_PKTEND_N, output, 1 bit: FX2 packet commit, active-low.
REQ-014 SHALL have port USB_STREAM_FIFOADDR, output, 2 bits: constant 2'b10.
REQ-015 SHALL have ports USB_STREAM_SLOE_N and USB_STREAM_SLRD_N, output, 1 bit each: constant 1.
REQ-016 SHALL have port WORD_CNT, output, 32 bits: count of 32-bit words fully sent; wraps modulo 2^32.

Function
REQ-017 SHALL implement the states IDLE, WR_LO, WR_HI and PKTEND.
REQ-018 In IDLE, when EN=1, FIFO_EMPTY=0, FX2RDY=1 and FLAGS_N[1]=1, the block SHALL pulse FIFO_READ for one cycle, latch FIFO_DATA into a 32-bit hold register and enter WR_LO on the next edge.
REQ-019 SHALL drive DATA_O with hold[15:0] in WR_LO, hold[31:16] in WR_HI, and hold[15:0] in all other states.
REQ-020 SLWR_N SHALL be combinational: 0 iff the state is WR_LO or WR_HI and FLAGS_N[1]=1.
REQ-021 A state SHALL advance only on a cycle with SLWR_N=0; while FLAGS_N[1]=0 the state and data SHALL hold with no write.
REQ-022 Each SLWR_N=0 cycle SHALL increment the packet counter pkt_cnt (range 0..PKT_WORDS) by 1.
REQ-023 After the WR_HI write, the block SHALL increment WORD_CNT and choose the next state as follows:
- pkt_cnt+1 = PKT_WORDS: clear pkt_cnt and go to IDLE; the FX2 auto-commits the packet and PKTEND_N is not asserted.
- otherwise, if EN=1 and FIFO_EMPTY=0 (FX2RDY not re-checked): pulse FIFO_READ, latch the new word and go to WR_LO, giving back-to-back transfer at 16 bits per cycle.
- otherwise: go to IDLE.
REQ-024 FX2RDY deassertion and EN=0 SHALL only block starting a new word; a word already latched SHALL always complete both halves.
REQ-025 SHALL keep an idle timer that counts cycles in IDLE while pkt_cnt>0 and resets on any write.
REQ-026 When the idle timer reaches FLUSH_TIMEOUT-1, the block SHALL enter PKTEND.
REQ-027 In PKTEND the block SHALL assert PKTEND_N=0 only on a cycle with FLAGS_N[1]=1, and on that cycle clear pkt_cnt and the timer and return to IDLE.
REQ-028 PKTEND SHALL have priority over starting a new word.
REQ-029 The timer SHALL saturate and never wrap; PKTEND SHALL never occur while pkt_cnt=0.
REQ-030 FIFO_READ SHALL never be asserted while FIFO_EMPTY=1 and SHALL be asserted at most once per latched word.

Reset
REQ-031 On RST_N=0, asynchronously: state IDLE; hold, pkt_cnt, timer and WORD_CNT = 0; FIFO_READ=0; SLWR_N=1; PKTEND_N=1; DATA_O=0.
REQ-032 Reset in the middle of a word SHALL discard the latched word without re-reading it; the first write after reset is the next FIFO word.
REQ-033 Release of RST_N SHALL take effect on the next CLK edge; no write occurs in the first cycle after release.

Verification
REQ-034 Single word: FIFO holds 32'hDEADBEEF, flags all ready -> one FIFO_READ pulse; writes 16'hBEEF then 16'hDEAD on consecutive cycles; WORD_CNT=1; PKTEND_N pulses once FLUSH_TIMEOUT cycles later.
REQ-035 Full packet: PKT_WORDS=8, 4 words continuously available -> 8 consecutive SLWR_N=0 cycles; no PKTEND_N; pkt_cnt=0 afterwards.
REQ-036 Back-pressure: FLAGS_N[1]=0 for 5 cycles during WR_HI -> SLWR_N=1 and DATA_O frozen at the upper half; the write resumes on the first ready cycle with no data lost or duplicated.
REQ-037 Gating: FX2RDY=0 or EN=0 with data present -> no FIFO_READ; dropping either during WR_LO still completes WR_HI.
REQ-038 Reset mid-word: RST_N=0 in WR_HI -> outputs return to reset values immediately; the next word sent is FIFO entry n+1.
REQ-039 Count wrap: WORD_CNT preloaded by force to 32'hFFFFFFFF, then one word sent -> WORD_CNT=0.
